pipe_ctrl: RTL and testbench

Pipeline sequencer for the 16-bit, 12-bit-PC three-stage core (IF/ID/IE). It generates the global `enable` consumed by the branch unit and every pipeline register, and tracks per-stage valid bits, applying the branch unit's 2-bit `flash` flush request. It also stalls the pipe on IE-stage data-memory accesses until acknowledged, with a timeout, and halts the core on a halt instruction.

---
 rtl/pipe_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline sequencer: enable, stage valids, memory stall, halt
module pipe_ctrl #(
  parameter int TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [1:0]  flash,
  input  logic        memreq,
  input  logic        memack,
  input  logic        haltinst,
  output logic        enable,
  output logic        pcwe,
  output logic        ifvalid,
  output logic        idvalid,
  output logic        ievalid,
  output logic [1:0]  state,
  output logic [15:0] stallcnt,
  output logic [15:0] flushcnt,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_MEMWAIT = 2'b10,
    S_HALT    = 2'b11
  } state_t;

  // Last stalled cycle index before the access is declared dead.
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_waitcnt;
  logic        r_ifvalid;
  logic        r_idvalid;
  logic        r_ievalid;
  logic [15:0] r_stallcnt;
  logic [15:0] r_flushcnt;
  logic        r_timeout;

  logic        w_halt_req;
  logic        w_mem_stall;
  logic        w_enable;
  logic        w_stall_inc;
  logic        w_flush1;
  logic        w_flush2;
  logic [1:0]  w_flush_add;
  logic [16:0] w_flush_sum;

  // Only a live IE instruction may halt or stall the pipe.
  assign w_halt_req  = haltinst & r_ievalid;
  assign w_mem_stall = memreq & r_ievalid & ~memack;
  assign w_flush1    = (flash == 2'b01);
  assign w_flush2    = (flash == 2'b10);

  // Global advance decision; drops in the same cycle as an unacknowledged access.
  always_comb begin
    w_enable = 1'b0;
    case (r_state)
      S_RUN:     w_enable = ~w_halt_req & ~w_mem_stall;
      S_MEMWAIT: w_enable = memack;
      default:   w_enable = 1'b0;
    endcase
  end

  // Stall cycles: the RUN entry cycle plus every MEMWAIT cycle without an ack.
  assign w_stall_inc = ((r_state == S_RUN) & ~w_halt_req & w_mem_stall) |
                       ((r_state == S_MEMWAIT) & ~memack);

  assign w_flush_add = ~w_enable ? 2'd0 : (w_flush2 ? 2'd2 : (w_flush1 ? 2'd1 : 2'd0));
  assign w_flush_sum = {1'b0, r_flushcnt} + {15'd0, w_flush_add};

  // Sequencer FSM with memory-wait timeout; HALT is only left through reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_waitcnt <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_halt_req) begin
            r_state <= S_HALT;
          end else if (w_mem_stall) begin
            r_state   <= S_MEMWAIT;
            r_waitcnt <= 8'd1;
          end
        end
        S_MEMWAIT: begin
          if (memack) begin
            r_state <= S_RUN;
          end else if (r_waitcnt == LP_LAST_WAIT) begin
            r_state   <= S_HALT;
            r_timeout <= 1'b1;
          end else begin
            r_waitcnt <= r_waitcnt + 8'd1;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  // Stage valid shift with flush kill, applied only on advancing edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ifvalid <= 1'b0;
      r_idvalid <= 1'b0;
      r_ievalid <= 1'b0;
    end else if (w_enable) begin
      r_ievalid <= r_idvalid;
      r_idvalid <= w_flush2 ? 1'b0 : r_ifvalid;
      r_ifvalid <= ~(w_flush1 | w_flush2);
    end
  end

  // Saturating stall and flushed-slot counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stallcnt <= 16'd0;
      r_flushcnt <= 16'd0;
    end else begin
      if (w_stall_inc && (r_stallcnt != 16'hFFFF)) r_stallcnt <= r_stallcnt + 16'd1;
      r_flushcnt <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
    end
  end

  assign enable   = w_enable;
  assign pcwe     = w_enable;
  assign ifvalid  = r_ifvalid;
  assign idvalid  = r_idvalid;
  assign ievalid  = r_ievalid;
  assign state    = r_state;
  assign stallcnt = r_stallcnt;
  assign flushcnt = r_flushcnt;
  assign timeout  = r_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [1:0]  flash = 2'b00;
  logic        memreq = 1'b0;
  logic        memack = 1'b0;
  logic        haltinst = 1'b0;
  logic        enable, pcwe, ifvalid, idvalid, ievalid, timeout;
  logic [1:0]  state;
  logic [15:0] stallcnt, flushcnt;

  pipe_ctrl #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .run(run), .flash(flash),
    .memreq(memreq), .memack(memack), .haltinst(haltinst),
    .enable(enable), .pcwe(pcwe), .ifvalid(ifvalid), .idvalid(idvalid),
    .ievalid(ievalid), .state(state), .stallcnt(stallcnt),
    .flushcnt(flushcnt), .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit en;
    int st;
    bit vif;
    bit vid;
    bit vie;
    int stall;
    int flush;
    bit to;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: state code, pipe occupancy [IF,ID,IE], counters.
  int   m_st = 0;
  bit   m_pipe[3];
  int   m_run = 0;
  int   m_stall = 0;
  int   m_flush = 0;
  bit   m_to = 0;
  bit   m_last_en = 0;
  logic [1:0] m_last_flash = 2'b00;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // One clock cycle of stimulus; inputs change on the falling edge.
  task automatic cyc(input bit r, input logic [1:0] f, input bit mq, input bit ma,
                     input bit hi, input bit rs);
    exp_t e;
    bit   en;
    int   nst;
    @(negedge clock);
    reset = rs; run = r; flash = f; memreq = mq; memack = ma; haltinst = hi;
    m_last_flash = f;
    if (rs) begin
      m_st = 0; m_run = 0; m_stall = 0; m_flush = 0; m_to = 0;
      m_pipe[0] = 0; m_pipe[1] = 0; m_pipe[2] = 0;
    end
    en = 0;
    if (m_st == 1) en = !(hi && m_pipe[2]) && !(mq && m_pipe[2] && !ma);
    else if (m_st == 2) en = ma;
    e.en = en; e.st = m_st; e.vif = m_pipe[0]; e.vid = m_pipe[1]; e.vie = m_pipe[2];
    e.stall = m_stall; e.flush = m_flush; e.to = m_to;
    exp_q.push_back(e);
    if (!rs) begin
      nst = m_st;
      if (m_st == 0 && r) nst = 1;
      else if (m_st == 1 && m_pipe[2] && hi) nst = 3;
      else if (m_st == 1 && m_pipe[2] && mq && !ma) begin
        nst = 2; m_run = 1; m_stall = sat(m_stall + 1);
      end else if (m_st == 2 && ma) nst = 1;
      else if (m_st == 2) begin
        m_run++; m_stall = sat(m_stall + 1);
        if (m_run == TO) begin nst = 3; m_to = 1; end
      end
      if (en) begin
        m_flush = sat(m_flush + ((f == 2'b01) ? 1 : (f == 2'b10) ? 2 : 0));
        m_pipe[2] = m_pipe[1];
        m_pipe[1] = (f == 2'b10) ? 1'b0 : m_pipe[0];
        m_pipe[0] = !(f == 2'b01 || f == 2'b10);
      end
      m_st = nst;
    end
    m_last_en = en;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 0, 0, 0, 0);
  endtask

  // Monitor: compares every pending expectation shortly after the inputs settle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("enable",   int'(enable),   int'(e.en));
        chk("pcwe",     int'(pcwe),     int'(e.en));
        chk("state",    int'(state),    e.st);
        chk("ifvalid",  int'(ifvalid),  int'(e.vif));
        chk("idvalid",  int'(idvalid),  int'(e.vid));
        chk("ievalid",  int'(ievalid),  int'(e.vie));
        chk("stallcnt", int'(stallcnt), e.stall);
        chk("flushcnt", int'(flushcnt), e.flush);
        chk("timeout",  int'(timeout),  int'(e.to));
      end
    end
  end

  initial begin
    int halt_age;
    bit r, mq, ma, hi, rs;
    logic [1:0] f;

    // start, ignored halt/memreq on an empty IE, fill
    cyc(0, 2'b00, 0, 0, 0, 1);
    idle(2);
    cyc(1, 2'b00, 0, 0, 0, 0);
    cyc(0, 2'b00, 1, 0, 1, 0);
    idle(3);
    // flush 2 then flush 1
    cyc(0, 2'b10, 0, 0, 0, 0);
    cyc(0, 2'b01, 0, 0, 0, 0);
    idle(3);
    // memory wait acked in the third MEMWAIT cycle, then zero-wait accesses
    for (int i = 0; i < 3; i++) cyc(0, 2'b00, 1, 0, 0, 0);
    cyc(0, 2'b00, 1, 1, 0, 0);
    cyc(0, 2'b00, 1, 1, 0, 0);
    cyc(0, 2'b10, 1, 1, 0, 0);
    idle(3);
    // halt beats memory stall, HALT ignores run
    cyc(0, 2'b00, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 2'b00, 0, 0, 0, 0);
    // timeout without ack
    cyc(0, 2'b00, 0, 0, 0, 1);
    cyc(1, 2'b00, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < TO + 2; i++) cyc(0, 2'b00, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 2'b00, 0, 0, 0, 0);
    // ack in the final wait cycle beats timeout
    cyc(0, 2'b00, 0, 0, 0, 1);
    cyc(1, 2'b00, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < TO - 1; i++) cyc(0, 2'b00, 1, 0, 0, 0);
    cyc(0, 2'b00, 1, 1, 0, 0);
    idle(2);
    // asynchronous reset in the middle of a stall
    for (int i = 0; i < 3; i++) cyc(0, 2'b00, 1, 0, 0, 0);
    cyc(0, 2'b00, 1, 0, 0, 1);
    idle(2);

    // randomized traffic
    halt_age = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(1) == 0);
      mq = ($urandom_range(3) == 0);
      ma = ($urandom_range(2) == 0);
      hi = ($urandom_range(39) == 0);
      rs = ($urandom_range(299) == 0);
      halt_age = (m_st == 3) ? halt_age + 1 : 0;
      if (halt_age > 3) rs = 1;
      if (!m_last_en && (m_st == 1 || m_st == 2)) f = m_last_flash;
      else f = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
      cyc(r, f, mq, ma, hi, rs);
    end
    cyc(0, 2'b00, 0, 0, 0, 0);

    @(negedge clock);
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
